// File: rtl/sha2_sigma_pipe.sv
// Two-stage pipelined SHA-2 sigma unit (Sigma0/Sigma1/sigma0/sigma1) for 32- or 64-bit words,
// with valid/ready handshake, sideband tag and a saturating output-transfer counter.
module sha2_sigma_pipe #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned TAG_WIDTH   = 4,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_mode,
  input  logic [DATA_WIDTH-1:0]  in_data,
  input  logic [TAG_WIDTH-1:0]   in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [1:0]             out_mode,
  output logic [TAG_WIDTH-1:0]   out_tag,
  output logic [COUNT_WIDTH-1:0] done_count
);

  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("sha2_sigma_pipe: DATA_WIDTH must be 32 or 64");
  end

  localparam bit IS64 = (DATA_WIDTH == 64);

  // Rotate/shift amounts: big Sigma0/1 are three rotations, small sigma0/1 end in a shift.
  localparam int unsigned BS0_A = IS64 ? 28 : 2;
  localparam int unsigned BS0_B = IS64 ? 34 : 13;
  localparam int unsigned BS0_C = IS64 ? 39 : 22;
  localparam int unsigned BS1_A = IS64 ? 14 : 6;
  localparam int unsigned BS1_B = IS64 ? 18 : 11;
  localparam int unsigned BS1_C = IS64 ? 41 : 25;
  localparam int unsigned SS0_A = IS64 ? 1  : 7;
  localparam int unsigned SS0_B = IS64 ? 8  : 18;
  localparam int unsigned SS0_C = IS64 ? 7  : 3;
  localparam int unsigned SS1_A = IS64 ? 19 : 17;
  localparam int unsigned SS1_B = IS64 ? 61 : 19;
  localparam int unsigned SS1_C = IS64 ? 6  : 10;

  function automatic logic [DATA_WIDTH-1:0] rotr(input logic [DATA_WIDTH-1:0] x,
                                                  input int unsigned n);
    return (x >> n) | (x << (DATA_WIDTH - n));
  endfunction

  logic                   v1_q, v2_q;
  logic [DATA_WIDTH-1:0]  a_q, b_q, c_q;
  logic [DATA_WIDTH-1:0]  a_d, b_d, c_d;
  logic [1:0]             mode1_q, mode2_q;
  logic [TAG_WIDTH-1:0]   tag1_q, tag2_q;
  logic [DATA_WIDTH-1:0]  data2_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   r1, r2;

  assign r2       = !v2_q || out_ready;
  assign r1       = !v1_q || r2;
  assign in_ready = r1;

  // Stage-1 term selection
  always_comb begin
    a_d = '0;
    b_d = '0;
    c_d = '0;
    unique case (in_mode)
      2'd0: begin a_d = rotr(in_data, BS0_A); b_d = rotr(in_data, BS0_B); c_d = rotr(in_data, BS0_C); end
      2'd1: begin a_d = rotr(in_data, BS1_A); b_d = rotr(in_data, BS1_B); c_d = rotr(in_data, BS1_C); end
      2'd2: begin a_d = rotr(in_data, SS0_A); b_d = rotr(in_data, SS0_B); c_d = in_data >> SS0_C; end
      default: begin a_d = rotr(in_data, SS1_A); b_d = rotr(in_data, SS1_B); c_d = in_data >> SS1_C; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      mode1_q <= '0;
      tag1_q  <= '0;
      data2_q <= '0;
      mode2_q <= '0;
      tag2_q  <= '0;
      count_q <= '0;
    end else begin
      if (r1) begin
        v1_q <= in_valid;
        if (in_valid) begin
          a_q     <= a_d;
          b_q     <= b_d;
          c_q     <= c_d;
          mode1_q <= in_mode;
          tag1_q  <= in_tag;
        end
      end
      if (r2) begin
        v2_q <= v1_q;
        if (v1_q) begin
          data2_q <= a_q ^ b_q ^ c_q;
          mode2_q <= mode1_q;
          tag2_q  <= tag1_q;
        end
      end
      if (v2_q && out_ready && (count_q != {COUNT_WIDTH{1'b1}})) begin
        count_q <= count_q + COUNT_WIDTH'(1);
      end
    end
  end

  assign out_valid  = v2_q;
  assign out_data   = data2_q;
  assign out_mode   = mode2_q;
  assign out_tag    = tag2_q;
  assign done_count = count_q;

endmodule
